// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: widths, 7-segment
// codes (segment order {a,b,c,d,e,f,g,dp}, active-high), conversion FSM
// states and the double-dabble nibble correction.
package calc_pkg;

  localparam int unsigned BIN_W = 10;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEG_W = 8;
  localparam int unsigned DIG_N = 3;

  localparam logic [BIN_W-1:0] MAX_VALUE = 10'd999;

  localparam logic [SEG_W-1:0] SEG_0     = 8'hfc;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h60;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hda;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hf2;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 8'hb6;
  localparam logic [SEG_W-1:0] SEG_6     = 8'hbe;
  localparam logic [SEG_W-1:0] SEG_7     = 8'he0;
  localparam logic [SEG_W-1:0] SEG_8     = 8'hfe;
  localparam logic [SEG_W-1:0] SEG_9     = 8'hf6;
  localparam logic [SEG_W-1:0] SEG_E     = 8'h9e;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Shift-add-3 correction applied to a BCD nibble before each shift.
  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 7-segment lookup for one digit.
// Ports: digit  - BCD digit 0..9
//        blank  - force all segments off
//        err    - show 'E' (wins over blank)
//        seg_c  - segment code {a,b,c,d,e,f,g,dp}
module seg_decode
  import calc_pkg::*;
(
  input  logic [3:0]       digit,
  input  logic             blank,
  input  logic             err,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (err) begin
      seg_c = SEG_E;
    end else if (!blank) begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Three-digit 7-segment display controller: sequential binary-to-BCD
// conversion (double-dabble) plus a free-running digit scanner.
// Ports: clk, rst (async, active-high)
//        load/value - request to show a 10-bit value (ignored while busy)
//        busy       - conversion in progress
//        done       - one-cycle pulse when bcd/err are committed
//        bcd, err   - committed digits {hundreds,tens,units} / overflow flag
//        seg        - segment bus {a..g,dp}, active-high
//        dig_sel    - digit enables, active-low (bit0 = units)
module seg_scan_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic             err,
  output logic [SEG_W-1:0] seg,
  output logic [DIG_N-1:0] dig_sel
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  state_t           state, state_nxt;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_acc, bcd_adj_c;
  logic [CNT_W-1:0] bit_cnt;
  logic             err_flag;
  logic             in_range_c, capture_c, reject_c, shift_c, commit_c;

  assign in_range_c = (value <= MAX_VALUE);

  // State register; busy is registered alongside so it tracks state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = in_range_c ? CONV : COMMIT;
      CONV:    if (bit_cnt == CNT_W'(1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath strobes decoded from state.
  always_comb begin
    capture_c = 1'b0;
    reject_c  = 1'b0;
    shift_c   = 1'b0;
    commit_c  = 1'b0;
    case (state)
      IDLE: begin
        capture_c = load && in_range_c;
        reject_c  = load && !in_range_c;
      end
      CONV:    shift_c  = 1'b1;
      COMMIT:  commit_c = 1'b1;
      default: ;
    endcase
  end

  // Add-3 on every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj_c = bcd_acc;
    for (int i = 0; i < DIG_N; i++) begin
      bcd_adj_c[4*i +: 4] = dabble_adj(bcd_acc[4*i +: 4]);
    end
  end

  // Conversion shift register and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sr   <= '0;
      bcd_acc  <= '0;
      bit_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (capture_c) begin
      bin_sr   <= value;
      bcd_acc  <= '0;
      bit_cnt  <= CNT_W'(BIN_W);
      err_flag <= 1'b0;
    end else if (reject_c) begin
      err_flag <= 1'b1;
    end else if (shift_c) begin
      {bcd_acc, bin_sr} <= {bcd_adj_c[BCD_W-2:0], bin_sr, 1'b0};
      bit_cnt           <= bit_cnt - CNT_W'(1);
    end
  end

  // Committed result: the only registers the display reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd  <= '0;
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= commit_c;
      if (commit_c) begin
        bcd <= err_flag ? BCD_W'(0) : bcd_acc;
        err <= err_flag;
      end
    end
  end

  // Free-running scan divider and digit index.
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       dig_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      dig_idx <= (dig_idx == 2'd2) ? 2'd0 : 2'(dig_idx + 2'd1);
    end else begin
      div_cnt <= DIV_W'(div_cnt + DIV_W'(1));
    end
  end

  // Pick the nibble, its leading-zero blank and its enable for this slot.
  logic [3:0]       sel_digit_c;
  logic             sel_blank_c;
  logic [DIG_N-1:0] sel_en_c;
  logic [SEG_W-1:0] seg_code_c;

  always_comb begin
    sel_digit_c = bcd[3:0];
    sel_blank_c = 1'b0;
    sel_en_c    = 3'b110;
    case (dig_idx)
      2'd1: begin
        sel_digit_c = bcd[7:4];
        sel_blank_c = BLANK_LZ && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        sel_en_c    = 3'b101;
      end
      2'd2: begin
        sel_digit_c = bcd[11:8];
        sel_blank_c = BLANK_LZ && (bcd[11:8] == 4'd0);
        sel_en_c    = 3'b011;
      end
      default: ;
    endcase
  end

  seg_decode u_seg_decode (
    .digit (sel_digit_c),
    .blank (sel_blank_c),
    .err   (err),
    .seg_c (seg_code_c)
  );

  // seg and dig_sel share one register stage so they switch together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg     <= SEG_BLANK;
      dig_sel <= 3'b111;
    end else begin
      seg     <= seg_code_c;
      dig_sel <= sel_en_c;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Display controller for the calculator's three-digit 7-segment readout. It accepts a binary result from the arithmetic core and converts it to BCD sequentially with shift-add-3 (double-dabble). It then time-multiplexes the three digits onto a shared segment bus, decoding each digit through a segment lookup. It sits between the calculator datapath and the board's LED pins, and it owns all display timing.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays selected; legal range 2..2^20.
- BLANK_LZ, 1: 1 blanks leading zeros, 0 shows all digits.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  request to display `value`; sampled only while `busy`=0.
- value  in  10  unsigned binary 0..1023.
- busy  out  1  conversion in progress; `load` is ignored while high.
- done  out  1  one-cycle pulse when the new digits are committed.
- bcd  out  12  committed BCD {hundreds, tens, units}.
- err  out  1  committed value was >999.
- seg  out  8  segments {a,b,c,d,e,f,g,dp}, active-high.
- dig_sel  out  3  digit enables, active-low; bit0 = units, bit2 = hundreds.

## Operation
- Conversion FSM has 3 states: IDLE, CONV, COMMIT. `busy` = (state != IDLE).
- IDLE + load + value<=999:
  - capture value in a shift register;
  - clear the BCD accumulator;
  - load bit counter = 10;
  - go to CONV.
- IDLE + load + value>999: go to COMMIT with the error flag set; the accumulator is not used.
- CONV, each cycle:
  - any BCD nibble >=5 gets +3 first;
  - then shift {bcd_acc, bin} left by 1;
  - decrement the counter;
  - at counter = 1 (last shift), go to COMMIT.
- COMMIT:
  - `bcd` <= accumulator (or 12'h000 if error);
  - `err` <= flag;
  - `done` = 1;
  - go to IDLE.
- Committed registers change only in COMMIT. The display never shows a partial conversion.
- Scanner:
  - free-running divider 0..SCAN_DIV-1;
  - on wrap, digit index advances 0→1→2→0;
  - the scanner runs independently of the FSM.
- Segment codes (hex): 0 fc, 1 60, 2 da, 3 f2, 4 66, 5 b6, 6 be, 7 e0, 8 fe, 9 f6, E 9e, blank 00. dp is always 0.
- When `err`=1, every digit shows E.
- Blanking with BLANK_LZ=1:
  - hundreds blank if 0;
  - tens blank if hundreds and tens are both 0;
  - units are never blanked.
- `seg` and `dig_sel` are registered together, so they always change on the same edge.

## Timing
- Reset values:
  - state IDLE, busy 0, done 0, err 0, bcd 12'h000;
  - divider 0, index 0;
  - seg 8'h00, dig_sel 3'b111 (all off).
- The first clock after reset drives index 0: dig_sel 3'b110, seg fc.
- Latency, normal value: load sampled at edge N.
  - busy is high after N;
  - 10 shifts on edges N+1..N+10;
  - COMMIT after N+10;
  - bcd/err/done update after edge N+11, and busy drops at the same time.
- Latency, value>999: done after edge N+1.
- A new load may be sampled on the edge where done is high (busy=0), giving back-to-back conversions every 12 cycles.
- Each digit is held for exactly SCAN_DIV cycles. seg/dig_sel follow the index change by 1 cycle.
- Reset mid-conversion: the conversion is aborted and all registers return to reset values immediately (asynchronous).
- A load asserted during reset is lost.

## Structure
- Shared package `calc_pkg`:
  - segment-code localparams (SEG_0..SEG_9, SEG_E, SEG_BLANK);
  - FSM state enum.
- Sub-module `seg_decode`: combinational 4-bit digit + blank + err → 8-bit segment code. It is instantiated once, on the selected nibble.

## Test plan
- Reset, then load value=10'd123 → done after 12 cycles, bcd=12'h123, err=0. Scan shows units f2, tens da, hundreds 60 with dig_sel 110/101/011.
- value=10'd7, BLANK_LZ=1 → hundreds and tens seg=00, units e0. Repeat with BLANK_LZ=0 → fc, fc, e0.
- value=10'd1000 → done 2 cycles after load, err=1, bcd=000, every digit seg=9e.
- load pulsed every cycle → only loads sampled with busy=0 take effect. Values 999 then 0 give bcd 999, then 000 with leading blanks.
- Assert rst 5 cycles after a load of 456:
  - busy, done, err, bcd clear immediately;
  - seg=00, dig_sel=111;
  - no done pulse follows.
- SCAN_DIV=4 → each dig_sel value is held exactly 4 cycles. A commit landing mid-slot updates seg within 1 cycle without changing the slot timing.
